// File: rtl/mod_inverse_pkg.sv
// Shared state encoding and default width for the modular-inverse engine.
package mod_inverse_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        CHECK,
        DIV,
        UPDATE,
        FIX
    } state_t;

endpackage

// File: rtl/mod_inverse_divider.sv
// Restoring serial divider: one quotient bit per cycle, ready pulses in the
// WIDTH-th cycle after go; quotient and remainder hold until the next go.
module mod_inverse_divider
    import mod_inverse_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_den;
    logic [CW-1:0]    r_count;
    logic             r_active;
    logic             r_ready;

    logic [WIDTH-1:0] w_remIn;
    logic [WIDTH-1:0] w_quotIn;
    logic [WIDTH-1:0] w_den;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // The go cycle already performs the first step on the fresh operands.
    assign w_remIn  = go ? '0 : r_rem;
    assign w_quotIn = go ? dividend : r_quot;
    assign w_den    = go ? divisor : r_den;
    assign w_trial  = {w_remIn, w_quotIn[WIDTH-1]};
    assign w_diff   = w_trial - {1'b0, w_den};
    assign w_fits   = ~w_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot   <= '0;
            r_rem    <= '0;
            r_den    <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (go || r_active) begin
                r_quot <= {w_quotIn[WIDTH-2:0], w_fits};
                r_rem  <= w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_den  <= w_den;
                if (go) begin
                    r_count  <= CW'(1);
                    r_active <= (WIDTH > 1);
                    r_ready  <= (WIDTH == 1);
                end else if (r_count == CW'(WIDTH - 1)) begin
                    r_active <= 1'b0;
                    r_ready  <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign ready     = r_ready;

endmodule

// File: rtl/mod_inverse_engine.sv
// Sequential d = e^-1 mod L via the iterative extended Euclidean algorithm,
// sharing one serial divider between the initial reduction and every step.
module mod_inverse_engine
    import mod_inverse_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] L,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             no_inverse
);

    state_t                r_state;
    logic [WIDTH-1:0]      r_e;
    logic [WIDTH-1:0]      r_L;
    logic [WIDTH-1:0]      r_r0;
    logic [WIDTH-1:0]      r_r1;
    logic [WIDTH-1:0]      r_q;
    logic [WIDTH-1:0]      r_d;
    logic signed [WIDTH:0] r_t0;
    logic signed [WIDTH:0] r_t1;
    logic                  r_reduceGo;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_noInverse;

    logic                  w_divGo;
    logic                  w_divReady;
    logic [WIDTH-1:0]      w_divDividend;
    logic [WIDTH-1:0]      w_divDivisor;
    logic [WIDTH-1:0]      w_quotient;
    logic [WIDTH-1:0]      w_remainder;
    logic signed [WIDTH:0] w_prod;
    logic signed [WIDTH:0] w_tNext;
    logic [WIDTH-1:0]      w_dPos;

    // Reduction divides the latched e by L (held in r0); later steps divide r0 by r1.
    assign w_divGo       = r_reduceGo || ((r_state == CHECK) && (r_r1 != '0));
    assign w_divDividend = r_reduceGo ? r_e : r_r0;
    assign w_divDivisor  = r_reduceGo ? r_r0 : r_r1;

    assign w_prod  = $signed({1'b0, r_q}) * r_t1;
    assign w_tNext = r_t0 - w_prod;
    assign w_dPos  = r_t0[WIDTH] ? (r_t0[WIDTH-1:0] + r_L) : r_t0[WIDTH-1:0];

    mod_inverse_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .go        (w_divGo),
        .dividend  (w_divDividend),
        .divisor   (w_divDivisor),
        .quotient  (w_quotient),
        .remainder (w_remainder),
        .ready     (w_divReady)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_e         <= '0;
            r_L         <= '0;
            r_r0        <= '0;
            r_r1        <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_t0        <= '0;
            r_t1        <= '0;
            r_reduceGo  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_noInverse <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !r_busy) begin
                        r_e    <= e;
                        r_L    <= L;
                        r_busy <= 1'b1;
                        // L < 2 enters CHECK with r1 = 0, so it falls into FIX with r0 = 0.
                        if (L < WIDTH'(2)) begin
                            r_r0    <= '0;
                            r_r1    <= '0;
                            r_state <= CHECK;
                        end else begin
                            r_r0       <= L;
                            r_t0       <= '0;
                            r_t1       <= (WIDTH+1)'(1);
                            r_reduceGo <= 1'b1;
                            r_state    <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    r_reduceGo <= 1'b0;
                    if (w_divReady) begin
                        r_r1    <= w_remainder;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_state <= (r_r1 != '0) ? DIV : FIX;
                end
                DIV: begin
                    if (w_divReady) begin
                        r_q     <= w_quotient;
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_r0    <= r_r1;
                    r_r1    <= w_remainder;
                    r_t0    <= r_t1;
                    r_t1    <= w_tNext;
                    r_state <= CHECK;
                end
                FIX: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    if (r_r0 == WIDTH'(1)) begin
                        r_d         <= w_dPos;
                        r_noInverse <= 1'b0;
                    end else begin
                        r_d         <= '0;
                        r_noInverse <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign d          = r_d;
    assign no_inverse = r_noInverse;

endmodule

// File: tb/tb_mod_inverse_engine.sv
// Self-checking bench: directed scenarios plus a random sweep, all checked
// against a brute-force inverse search and the closed-form latency.
module tb_mod_inverse_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic [7:0]  e8 = '0;
    logic [7:0]  L8 = '0;
    logic        busy8, done8, noinv8;
    logic [7:0]  d8;
    logic        start12 = 1'b0;
    logic [11:0] e12 = '0;
    logic [11:0] L12 = '0;
    logic        busy12, done12, noinv12;
    logic [11:0] d12;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    mod_inverse_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .e(e8), .L(L8),
        .busy(busy8), .done(done8), .d(d8), .no_inverse(noinv8)
    );

    mod_inverse_engine #(.WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .e(e12), .L(L12),
        .busy(busy12), .done(done12), .d(d12), .no_inverse(noinv12)
    );

    // Reference: exhaustive search for the unique d in [1, L-1] with d*e = 1 (mod L).
    function automatic int modelInverse(int ev, int lv);
        for (int x = 1; x < lv; x++)
            if ((longint'(x) * longint'(ev)) % longint'(lv) == 1) return x;
        return 0;
    endfunction

    function automatic int modelGcd(int a, int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // k counts the Euclid divisions performed after reducing e modulo L.
    function automatic int modelLatency(int w, int ev, int lv);
        int a, b, t, k;
        if (lv < 2) return 2;
        a = lv;
        b = ev % lv;
        k = 0;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
            k++;
        end
        return w + 3 + k * (w + 2);
    endfunction

    // Starts one operation on the chosen instance and waits (bounded) for done.
    task automatic runOp(input bit wide, input int ev, input int lv,
                         output int dOut, output bit nOut, output int lat,
                         output bit busyOk, output bit timedOut);
        int  cycles;
        bit  seen;
        busyOk   = 1'b1;
        timedOut = 1'b0;
        seen     = 1'b0;
        @(negedge clk);
        if (wide) begin
            e12 = ev[11:0];
            L12 = lv[11:0];
            start12 = 1'b1;
        end else begin
            e8 = ev[7:0];
            L8 = lv[7:0];
            start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start12 = 1'b0;
        cycles  = 0;
        while (!seen && cycles < 3000) begin
            if ((wide ? busy12 : busy8) !== 1'b1) busyOk = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
            if ((wide ? done12 : done8) === 1'b1) seen = 1'b1;
        end
        timedOut = !seen;
        lat  = cycles;
        dOut = wide ? int'(d12) : int'(d8);
        nOut = wide ? noinv12 : noinv8;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        nChecks++;
        if ({busy8, done8, noinv8, d8} !== 11'd0) begin
            nFails++;
            $display("[TB] FAIL reset8: got busy=%b done=%b noinv=%b d=%0d, expected all 0", busy8, done8, noinv8, d8);
        end
        nChecks++;
        if ({busy12, done12, noinv12, d12} !== 15'd0) begin
            nFails++;
            $display("[TB] FAIL reset12: got busy=%b done=%b noinv=%b d=%0d, expected all 0", busy12, done12, noinv12, d12);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int dv, lat;
        bit nv, bOk, tOut;
        runOp(0, 3, 20, dv, nv, lat, bOk, tOut);
        nChecks++;
        if (tOut) begin nFails++; $display("[TB] FAIL basic_timeout: got no done, expected done"); end
        nChecks++;
        if (dv !== 7 || nv !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL basic_result: got d=%0d noinv=%b, expected d=7 noinv=0", dv, nv);
        end
        nChecks++;
        if (lat !== 41) begin nFails++; $display("[TB] FAIL basic_latency: got %0d, expected 41", lat); end
        nChecks++;
        if (!bOk) begin nFails++; $display("[TB] FAIL basic_busy: got busy low before done, expected high throughout"); end
        nChecks++;
        if (busy8 !== 1'b0) begin nFails++; $display("[TB] FAIL basic_busy_at_done: got %b, expected 0", busy8); end
        @(posedge clk);
        #1;
        nChecks++;
        if (done8 !== 1'b0 || d8 !== 8'd7) begin
            nFails++;
            $display("[TB] FAIL basic_hold: got done=%b d=%0d, expected done=0 d=7", done8, d8);
        end
    endtask

    task automatic test_no_inverse_and_wide();
        int dv, lat;
        bit nv, bOk, tOut;
        runOp(0, 4, 20, dv, nv, lat, bOk, tOut);
        nChecks++;
        if (tOut || nv !== 1'b1 || dv !== 0) begin
            nFails++;
            $display("[TB] FAIL noinv_4_20: got d=%0d noinv=%b timeout=%b, expected d=0 noinv=1", dv, nv, tOut);
        end
        runOp(1, 17, 3120, dv, nv, lat, bOk, tOut);
        nChecks++;
        if (tOut || nv !== 1'b0 || dv !== 2753) begin
            nFails++;
            $display("[TB] FAIL wide_17_3120: got d=%0d noinv=%b timeout=%b, expected d=2753 noinv=0", dv, nv, tOut);
        end
        nChecks++;
        if (lat !== modelLatency(12, 17, 3120)) begin
            nFails++;
            $display("[TB] FAIL wide_latency: got %0d, expected %0d", lat, modelLatency(12, 17, 3120));
        end
    endtask

    task automatic test_reduce();
        int dv, lat;
        bit nv, bOk, tOut;
        runOp(0, 25, 20, dv, nv, lat, bOk, tOut);
        nChecks++;
        if (tOut || nv !== 1'b1 || dv !== 0) begin
            nFails++;
            $display("[TB] FAIL reduce_25_20: got d=%0d noinv=%b, expected d=0 noinv=1", dv, nv);
        end
        runOp(0, 23, 20, dv, nv, lat, bOk, tOut);
        nChecks++;
        if (tOut || nv !== 1'b0 || dv !== 7) begin
            nFails++;
            $display("[TB] FAIL reduce_23_20: got d=%0d noinv=%b, expected d=7 noinv=0", dv, nv);
        end
        nChecks++;
        if (lat !== modelLatency(8, 23, 20)) begin
            nFails++;
            $display("[TB] FAIL reduce_latency: got %0d, expected %0d", lat, modelLatency(8, 23, 20));
        end
    endtask

    task automatic test_small_modulus();
        int dv, lat;
        bit nv, bOk, tOut;
        int lvals[3] = '{1, 0, 20};
        int evals[3] = '{5, 9, 0};
        for (int i = 0; i < 3; i++) begin
            runOp(0, evals[i], lvals[i], dv, nv, lat, bOk, tOut);
            nChecks++;
            if (tOut || nv !== 1'b1 || dv !== 0) begin
                nFails++;
                $display("[TB] FAIL small_result e=%0d L=%0d: got d=%0d noinv=%b, expected d=0 noinv=1", evals[i], lvals[i], dv, nv);
            end
            nChecks++;
            if (lat !== modelLatency(8, evals[i], lvals[i])) begin
                nFails++;
                $display("[TB] FAIL small_latency e=%0d L=%0d: got %0d, expected %0d", evals[i], lvals[i], lat, modelLatency(8, evals[i], lvals[i]));
            end
        end
    endtask

    task automatic test_ignore_inputs();
        int cycles = 0;
        bit seen = 1'b0;
        @(negedge clk);
        e8 = 8'd3;
        L8 = 8'd20;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        while (!seen && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 3) begin
                e8 = 8'd200;
                L8 = 8'd77;
                start8 = 1'b1;
            end
            if (cycles == 8) start8 = 1'b0;
            if (done8 === 1'b1) seen = 1'b1;
        end
        nChecks++;
        if (!seen || d8 !== 8'd7 || noinv8 !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ignore_result: got d=%0d noinv=%b seen=%b, expected d=7 noinv=0", d8, noinv8, seen);
        end
        nChecks++;
        if (cycles !== 41) begin nFails++; $display("[TB] FAIL ignore_latency: got %0d, expected 41", cycles); end
    endtask

    task automatic test_abort_reset();
        int dv, lat;
        bit nv, bOk, tOut;
        bit sawDone = 1'b0;
        @(negedge clk);
        e8 = 8'd3;
        L8 = 8'd20;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        nChecks++;
        if ({busy8, done8, noinv8, d8} !== 11'd0) begin
            nFails++;
            $display("[TB] FAIL abort_outputs: got busy=%b done=%b noinv=%b d=%0d, expected all 0", busy8, done8, noinv8, d8);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1) sawDone = 1'b1;
        end
        nChecks++;
        if (sawDone) begin nFails++; $display("[TB] FAIL abort_no_done: got done=1, expected no done"); end
        runOp(0, 7, 20, dv, nv, lat, bOk, tOut);
        nChecks++;
        if (tOut || dv !== 3 || nv !== 1'b0 || lat !== modelLatency(8, 7, 20)) begin
            nFails++;
            $display("[TB] FAIL abort_restart: got d=%0d noinv=%b lat=%0d, expected d=3 noinv=0 lat=%0d", dv, nv, lat, modelLatency(8, 7, 20));
        end
    endtask

    task automatic test_random();
        int dv, lat, ev, lv, expD;
        bit nv, bOk, tOut, expN;
        for (int i = 0; i < 150; i++) begin
            ev = int'($urandom_range(255, 0));
            lv = int'($urandom_range(255, 0));
            expD = modelInverse(ev, lv);
            expN = (lv < 2) || (modelGcd(ev, lv) != 1);
            runOp(0, ev, lv, dv, nv, lat, bOk, tOut);
            nChecks++;
            if (tOut || nv !== expN) begin
                nFails++;
                $display("[TB] FAIL rand_noinv e=%0d L=%0d: got %b, expected %b", ev, lv, nv, expN);
            end
            nChecks++;
            if (dv !== expD) begin
                nFails++;
                $display("[TB] FAIL rand_d e=%0d L=%0d: got %0d, expected %0d", ev, lv, dv, expD);
            end
            nChecks++;
            if (lat !== modelLatency(8, ev, lv) || !bOk) begin
                nFails++;
                $display("[TB] FAIL rand_latency e=%0d L=%0d: got %0d busyOk=%b, expected %0d busyOk=1", ev, lv, lat, bOk, modelLatency(8, ev, lv));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_inverse_and_wide();
        test_reduce();
        test_small_modulus();
        test_ignore_inputs();
        test_abort_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
